vga_scan_timing: RTL

//  Raster scan generator feeding full_tile: produces pixel row/col coordinates, a pixel strobe and
//  VGA sync/blank. Sync and blank are delayed by PIPE_DELAY pixel strobes so they align with the

---
 rtl/vga_scan_timing_pkg.sv | 34 +++
 rtl/vga_scan_timing_if.sv | 22 ++
 rtl/vga_scan_timing_sync_delay_line.sv | 33 +++
 rtl/vga_scan_timing.sv | 133 +++++++++++++
 4 files changed

// File: rtl/vga_scan_timing_pkg.sv
// Shared video timing definitions: 640x480@60 defaults, counter width and the sync bundle
// carried through the colour-alignment delay line.
package vga_scan_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Counters are sized for the standard mode; smaller test geometries fit as well.
    localparam int CNT_W = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_t;

    function automatic sync_t sync_idle(input logic sync_act);
        sync_t s;
        s.hs    = ~sync_act;
        s.vs    = ~sync_act;
        s.blank = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/vga_scan_timing_if.sv
// Pixel-timing bundle from the raster generator to the tile pipeline and VGA pins.
interface vga_scan_timing_if;
    logic       pix_stb;
    logic [8:0] row;
    logic [9:0] col;
    logic       active;
    logic       line_start;
    logic       frame_start;
    logic       hsync_d;
    logic       vsync_d;
    logic       blank_d;

    modport master (
        output pix_stb, row, col, active, line_start, frame_start,
        output hsync_d, vsync_d, blank_d
    );

    modport slave (
        input pix_stb, row, col, active, line_start, frame_start,
        input hsync_d, vsync_d, blank_d
    );
endinterface

// File: rtl/vga_scan_timing_sync_delay_line.sv
// Enable-gated shift register: DEPTH+1 stages so that DEPTH=0 still yields a registered copy.
module vga_scan_timing_sync_delay_line
    import vga_scan_timing_pkg::*;
#(
    parameter int  DEPTH = 3,
    parameter type T     = sync_t
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  T     rst_val,
    input  T     d,
    output T     q
);

    T stage_reg [0:DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= DEPTH; i++) begin
                stage_reg[i] <= rst_val;
            end
        end else if (en) begin
            stage_reg[0] <= d;
            for (int i = 1; i <= DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign q = stage_reg[DEPTH];

endmodule

// File: rtl/vga_scan_timing.sv
// Raster scan generator: pixel divider, h/v counters, registered coordinates and
// sync/blank delayed to line up with the tile pipeline's colour output.
module vga_scan_timing
    import vga_scan_timing_pkg::*;
#(
    parameter int   CLK_DIV    = 4,
    parameter int   H_VISIBLE  = H_VISIBLE_DEF,
    parameter int   H_FP       = H_FP_DEF,
    parameter int   H_SYNC     = H_SYNC_DEF,
    parameter int   H_BP       = H_BP_DEF,
    parameter int   V_VISIBLE  = V_VISIBLE_DEF,
    parameter int   V_FP       = V_FP_DEF,
    parameter int   V_SYNC     = V_SYNC_DEF,
    parameter int   V_BP       = V_BP_DEF,
    parameter logic SYNC_ACT   = 1'b0,
    parameter int   PIPE_DELAY = 3
) (
    input  logic              clk,
    input  logic              rst,
    vga_scan_timing_if.master vid
);

    localparam int H_TOT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_reg;
    logic [CNT_W-1:0] hcnt_reg;
    logic [CNT_W-1:0] vcnt_reg;
    logic             tick;
    logic             h_last;
    logic             v_last;
    logic             active_now;
    sync_t            raw_sync;
    sync_t            sync_d;

    logic       pix_stb_reg;
    logic [8:0] row_reg;
    logic [9:0] col_reg;
    logic       active_reg;
    logic       line_start_reg;
    logic       frame_start_reg;

    // With CLK_DIV==1 the divider sits at 0 and tick is permanently high.
    assign tick   = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
    assign h_last = (hcnt_reg == CNT_W'(H_TOT - 1));
    assign v_last = (vcnt_reg == CNT_W'(V_TOT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
        end else if (tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else if (tick) begin
            if (h_last) begin
                hcnt_reg <= '0;
                vcnt_reg <= v_last ? '0 : vcnt_reg + 1'b1;
            end else begin
                hcnt_reg <= hcnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        active_now     = (hcnt_reg < CNT_W'(H_VISIBLE)) && (vcnt_reg < CNT_W'(V_VISIBLE));
        raw_sync.hs    = ~SYNC_ACT;
        raw_sync.vs    = ~SYNC_ACT;
        raw_sync.blank = ~active_now;
        if ((hcnt_reg >= CNT_W'(HS_START)) && (hcnt_reg < CNT_W'(HS_END))) begin
            raw_sync.hs = SYNC_ACT;
        end
        if ((vcnt_reg >= CNT_W'(VS_START)) && (vcnt_reg < CNT_W'(VS_END))) begin
            raw_sync.vs = SYNC_ACT;
        end
    end

    // Outputs capture the pixel the counters point at, so they appear together with pix_stb.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_stb_reg     <= 1'b0;
            row_reg         <= '0;
            col_reg         <= '0;
            active_reg      <= 1'b1;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            pix_stb_reg <= tick;
            if (tick) begin
                row_reg         <= active_now ? vcnt_reg[8:0] : '1;
                col_reg         <= active_now ? hcnt_reg[9:0] : '1;
                active_reg      <= active_now;
                line_start_reg  <= (hcnt_reg == '0) && (vcnt_reg < CNT_W'(V_VISIBLE));
                frame_start_reg <= (hcnt_reg == '0) && (vcnt_reg == '0);
            end
        end
    end

    vga_scan_timing_sync_delay_line #(
        .DEPTH (PIPE_DELAY),
        .T     (sync_t)
    ) u_sync_delay (
        .clk     (clk),
        .rst     (rst),
        .en      (tick),
        .rst_val (sync_idle(SYNC_ACT)),
        .d       (raw_sync),
        .q       (sync_d)
    );

    assign vid.pix_stb     = pix_stb_reg;
    assign vid.row         = row_reg;
    assign vid.col         = col_reg;
    assign vid.active      = active_reg;
    assign vid.line_start  = line_start_reg;
    assign vid.frame_start = frame_start_reg;
    assign vid.hsync_d     = sync_d.hs;
    assign vid.vsync_d     = sync_d.vs;
    assign vid.blank_d     = sync_d.blank;

endmodule
